control_operandos_alu: RTL and testbench

CONTROL_OPERANDOS_ALU -- requirements
Module: control_operandos_alu

---
 rtl/control_operandos_alu.sv | 125 ++++++++++++
 tb/tb_control_operandos_alu.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/control_operandos_alu.sv
// Operand/opcode sequencer for a pushbutton-driven ALU: loads A, B, op, then
// captures the ALU result with zero/negative/error flags. Buttons are raw inputs.
module control_operandos_alu #(
  parameter int N_BITS = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [N_BITS-1:0] dato_entrada,
  input  logic              boton_cargar,
  input  logic              boton_limpiar,
  input  logic [N_BITS-1:0] resultado_alu,
  output logic [N_BITS-1:0] entrada_a,
  output logic [N_BITS-1:0] entrada_b,
  output logic [2:0]        operacion,
  output logic [N_BITS-1:0] resultado_reg,
  output logic [2:0]        estado,
  output logic              valido,
  output logic              flag_cero,
  output logic              flag_negativo,
  output logic              flag_error
);

  typedef enum logic [2:0] {
    ESPERA_A  = 3'd0,
    ESPERA_B  = 3'd1,
    ESPERA_OP = 3'd2,
    CALCULO   = 3'd3,
    MOSTRAR   = 3'd4
  } estado_t;

  estado_t    est;
  estado_t    est_nxt;
  logic [1:0] sinc_c;
  logic [1:0] sinc_l;
  logic       prev_c;
  logic       sync_cargar;
  logic       sync_limpiar;
  logic       pulso_cargar;
  logic       captura;
  logic       op_ok;

  assign sync_cargar  = sinc_c[1];
  assign sync_limpiar = sinc_l[1];
  assign pulso_cargar = sync_cargar & ~prev_c;
  assign estado       = est;
  assign op_ok        = (operacion inside {3'd1, 3'd2, 3'd3, 3'd4});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sinc_c <= '0;
      sinc_l <= '0;
      prev_c <= 1'b0;
    end else begin
      sinc_c <= {sinc_c[0], boton_cargar};
      sinc_l <= {sinc_l[0], boton_limpiar};
      prev_c <= sync_cargar;
    end
  end

  always_comb begin
    est_nxt = est;
    case (est)
      ESPERA_A:  if (pulso_cargar) est_nxt = ESPERA_B;
      ESPERA_B:  if (pulso_cargar) est_nxt = ESPERA_OP;
      ESPERA_OP: if (pulso_cargar) est_nxt = CALCULO;
      CALCULO:   est_nxt = MOSTRAR;
      MOSTRAR:   if (pulso_cargar) est_nxt = ESPERA_B;
      default:   est_nxt = ESPERA_A;
    endcase
    if (sync_limpiar) est_nxt = ESPERA_A;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) est <= ESPERA_A;
    else          est <= est_nxt;
  end

  // The result is taken one edge after CALCULO exits, so operands and
  // opcode have been stable for a full cycle at the ALU output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      entrada_a     <= '0;
      entrada_b     <= '0;
      operacion     <= '0;
      resultado_reg <= '0;
      valido        <= 1'b0;
      flag_cero     <= 1'b0;
      flag_negativo <= 1'b0;
      flag_error    <= 1'b0;
      captura       <= 1'b0;
    end else if (sync_limpiar) begin
      entrada_a     <= '0;
      entrada_b     <= '0;
      operacion     <= '0;
      resultado_reg <= '0;
      valido        <= 1'b0;
      flag_cero     <= 1'b0;
      flag_negativo <= 1'b0;
      flag_error    <= 1'b0;
      captura       <= 1'b0;
    end else begin
      captura <= (est == CALCULO);
      if (captura) begin
        resultado_reg <= resultado_alu;
        valido        <= 1'b1;
        flag_cero     <= (resultado_alu == '0);
        flag_negativo <= resultado_alu[N_BITS-1];
        flag_error    <= ~op_ok;
      end
      case (est)
        ESPERA_A:  if (pulso_cargar) entrada_a <= dato_entrada;
        ESPERA_B:  if (pulso_cargar) entrada_b <= dato_entrada;
        ESPERA_OP: if (pulso_cargar) operacion <= dato_entrada[2:0];
        MOSTRAR: begin
          if (pulso_cargar) begin
            entrada_a <= dato_entrada;
            valido    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_operandos_alu.sv
// Scoreboard bench for control_operandos_alu with a behavioural ALU attached.
// Expected results are queued at opcode press and checked when valido rises.
module tb_control_operandos_alu;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] dato_entrada;
  logic       boton_cargar;
  logic       boton_limpiar;
  logic [7:0] resultado_alu;
  logic [7:0] entrada_a;
  logic [7:0] entrada_b;
  logic [2:0] operacion;
  logic [7:0] resultado_reg;
  logic [2:0] estado;
  logic       valido;
  logic       flag_cero;
  logic       flag_negativo;
  logic       flag_error;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  typedef struct {
    logic [7:0] res;
    logic       z;
    logic       n;
    logic       e;
    int         when;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    resultado_alu = 8'h00;
    case (operacion)
      3'b001: resultado_alu = entrada_a + entrada_b;
      3'b010: resultado_alu = entrada_a - entrada_b;
      3'b011: resultado_alu = entrada_a & entrada_b;
      3'b100: resultado_alu = entrada_a | entrada_b;
      default: resultado_alu = 8'h00;
    endcase
  end

  control_operandos_alu #(.N_BITS(8)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .dato_entrada  (dato_entrada),
    .boton_cargar  (boton_cargar),
    .boton_limpiar (boton_limpiar),
    .resultado_alu (resultado_alu),
    .entrada_a     (entrada_a),
    .entrada_b     (entrada_b),
    .operacion     (operacion),
    .resultado_reg (resultado_reg),
    .estado        (estado),
    .valido        (valido),
    .flag_cero     (flag_cero),
    .flag_negativo (flag_negativo),
    .flag_error    (flag_error)
  );

  function automatic exp_t modelo(input int a, input int b,
                                  input int op, input int when);
    exp_t x;
    int   r;
    if (op == 1)      r = a + b;
    else if (op == 2) r = a - b + 256;
    else if (op == 3) r = a & b;
    else if (op == 4) r = a | b;
    else              r = 0;
    r      = r % 256;
    x.res  = 8'(r);
    x.z    = (r == 0);
    x.n    = (r >= 128);
    x.e    = !(op >= 1 && op <= 4);
    x.when = when;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  logic pv = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (valido && !pv) begin
      if (sb.size() == 0) begin
        chk("unexpected_valido", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("resultado_reg", resultado_reg, e.res);
        chk("flag_cero", flag_cero, e.z);
        chk("flag_negativo", flag_negativo, e.n);
        chk("flag_error", flag_error, e.e);
        chk("latency_cycle", cyc, e.when);
      end
    end
    pv = valido;
  end

  task automatic press(input logic [7:0] d);
    @(negedge clk);
    dato_entrada = d;
    boton_cargar = 1'b1;
    repeat (2) @(negedge clk);
    boton_cargar = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic run_seq(input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] op);
    press(a);
    press(b);
    @(negedge clk);
    dato_entrada = {5'b0, op};
    boton_cargar = 1'b1;
    sb.push_back(modelo(int'(a), int'(b), int'(op), cyc + 5));
    repeat (2) @(negedge clk);
    boton_cargar = 1'b0;
    for (int i = 0; i < 10 && !valido; i++) @(negedge clk);
    chk("valido_timeout", valido, 1);
    @(negedge clk);
  endtask

  logic [7:0] keep_r;
  logic [7:0] keep_b;

  initial begin
    reset_n       = 1'b0;
    dato_entrada  = 8'h00;
    boton_cargar  = 1'b0;
    boton_limpiar = 1'b0;
    #3;
    chk("rst_estado", estado, 0);
    chk("rst_valido", valido, 0);
    chk("rst_a", entrada_a, 0);
    chk("rst_res", resultado_reg, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    run_seq(8'h05, 8'h03, 3'b001);
    chk("add_estado", estado, 4);
    chk("add_a", entrada_a, 8'h05);
    chk("add_b", entrada_b, 8'h03);
    run_seq(8'h03, 8'h05, 3'b010);
    run_seq(8'h5A, 8'h5A, 3'b010);
    run_seq(8'($urandom), 8'($urandom), 3'b111);

    keep_r = resultado_reg;
    keep_b = entrada_b;
    press(8'h11);
    chk("mostrar_a", entrada_a, 8'h11);
    chk("mostrar_valido", valido, 0);
    chk("mostrar_estado", estado, 1);
    chk("mostrar_res", resultado_reg, keep_r);
    chk("mostrar_b", entrada_b, keep_b);
    chk("mostrar_op", operacion, 3'b111);

    @(negedge clk);
    boton_limpiar = 1'b1;
    repeat (3) @(negedge clk);
    boton_limpiar = 1'b0;
    repeat (3) @(negedge clk);
    chk("clr_estado", estado, 0);
    chk("clr_a", entrada_a, 0);
    chk("clr_op", operacion, 0);

    @(negedge clk);
    dato_entrada = 8'h77;
    boton_cargar = 1'b1;
    repeat (5) @(negedge clk);
    dato_entrada = 8'h99;
    repeat (45) @(negedge clk);
    boton_cargar = 1'b0;
    repeat (4) @(negedge clk);
    chk("hold_estado", estado, 1);
    chk("hold_a", entrada_a, 8'h77);

    press(8'h22);
    chk("espera_op", estado, 2);
    @(negedge clk);
    dato_entrada  = 8'h03;
    boton_cargar  = 1'b1;
    boton_limpiar = 1'b1;
    repeat (3) @(negedge clk);
    boton_cargar  = 1'b0;
    boton_limpiar = 1'b0;
    repeat (4) @(negedge clk);
    chk("both_estado", estado, 0);
    chk("both_a", entrada_a, 0);
    chk("both_b", entrada_b, 0);
    chk("both_op", operacion, 0);
    chk("both_res", resultado_reg, 0);
    chk("both_flags", {valido, flag_cero, flag_negativo, flag_error}, 0);

    for (int i = 0; i < 20; i++)
      run_seq(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)));

    press(8'h0F);
    press(8'h01);
    @(negedge clk);
    dato_entrada = 8'h01;
    boton_cargar = 1'b1;
    for (int i = 0; i < 10 && estado != 3; i++) @(negedge clk);
    chk("reach_calculo", estado, 3);
    #1;
    reset_n = 1'b0;
    #1;
    chk("arst_estado", estado, 0);
    chk("arst_ab", {entrada_a, entrada_b}, 0);
    chk("arst_op", operacion, 0);
    chk("arst_res", resultado_reg, 0);
    chk("arst_flags", {valido, flag_cero, flag_negativo, flag_error}, 0);
    dato_entrada = 8'h44;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    boton_cargar = 1'b0;
    repeat (3) @(negedge clk);
    chk("rel_estado", estado, 1);
    chk("rel_a", entrada_a, 8'h44);
    chk("rel_valido", valido, 0);

    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
